// File: rtl/stream_demux_1xn_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer.
//   - Default payload width, channel count and select width.
//   - EMPTY/FULL encodings of a per-channel output slot.
//   - Width of the discarded-word counter.
// Optional feature: define STREAM_DEMUX_DROP_CNT_EN to build the
// discarded-word counter.
package stream_demux_1xn_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NCH    = 4;
  localparam int DEF_SEL_W  = 2;
  localparam int DROP_CNT_W = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/stream_demux_1xn_slot.sv
// demux_slot: one-entry output register for a single demux channel.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load             word accepted for this channel this cycle
//   load_data        payload to capture on load
//   out_ready        downstream accept for this channel
//   out_valid        slot is FULL
//   out_data         held payload (retained while EMPTY)
//   slot_ready       slot can take a word this cycle (empty or draining)
module demux_slot
  import stream_demux_1xn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              slot_ready
);

  slot_state_e       state_q;
  logic [DATA_W-1:0] data_q;

  // load is only ever raised while slot_ready is high, so a FULL slot
  // taking a load is always a same-cycle drain-and-reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (load) begin
            state_q <= SLOT_FULL;
            data_q  <= load_data;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            data_q <= load_data;
          end else if (out_ready) begin
            state_q <= SLOT_EMPTY;
          end
        end
        default: state_q <= SLOT_EMPTY;
      endcase
    end
  end

  assign out_valid  = (state_q == SLOT_FULL);
  assign out_data   = data_q;
  assign slot_ready = (state_q == SLOT_EMPTY) | out_ready;

endmodule

// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: routes one input stream to NCH output channels by
// in_sel, each channel buffered by a one-entry slot (1-cycle latency,
// full throughput). Words with in_sel >= NCH are accepted and dropped.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready upstream handshake; in_sel selects the channel
//   in_data           payload
//   out_valid[k]      channel k holds a word
//   out_ready[k]      channel k downstream accept
//   out_data          channel k at [k*DATA_W +: DATA_W]
//   drop_cnt          saturating count of dropped words
// Build option: STREAM_DEMUX_DROP_CNT_EN enables the drop counter;
// without it drop_cnt is tied to zero.
module stream_demux_1xn
  import stream_demux_1xn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NCH    = DEF_NCH,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [NCH-1:0] sel_hit;
  logic [NCH-1:0] slot_rdy;
  logic [NCH-1:0] load;
  logic           in_range;
  logic           accept;

  // One-hot decode of in_sel; all-zero when in_sel is out of range.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < NCH; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end
  end

  assign in_range = |sel_hit;

  // Out-of-range words are always taken so they can be discarded.
  assign in_ready = ~rst & (in_range ? |(sel_hit & slot_rdy) : 1'b1);
  assign accept   = in_valid & in_ready;
  assign load     = sel_hit & {NCH{accept}};

  for (genvar g = 0; g < NCH; g++) begin : g_slot
    demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load[g]),
      .load_data  (in_data),
      .out_ready  (out_ready[g]),
      .out_valid  (out_valid[g]),
      .out_data   (out_data[g*DATA_W +: DATA_W]),
      .slot_ready (slot_rdy[g])
    );
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  assign drop = accept & ~in_range;

  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
module tb_stream_demux_1xn;

  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int SW  = 3;   // sel 4..7 exercise the out-of-range path

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [SW-1:0]     in_sel;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*DW-1:0] out_data;
  logic [15:0]       drop_cnt;

  stream_demux_1xn #(.DATA_W(DW), .NCH(NCH), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: each channel is a queue of pending words (capacity 1),
  // plus the last word each channel was given (retained when empty).
  logic [DW-1:0] q_m [NCH][$];
  logic [DW-1:0] last_m [NCH];
  logic [15:0]   drop_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      q_m[k].delete();
      last_m[k] = '0;
    end
    drop_m = '0;
  endtask

  // Drive one cycle (called at negedge), compare everything against the
  // model before the edge, then advance the model across the edge.
  task automatic step(input logic r, input logic v, input logic [SW-1:0] s,
                      input logic [DW-1:0] d, input logic [NCH-1:0] ordy,
                      output logic rdy_seen);
    logic              exp_rdy;
    logic [NCH-1:0]    exp_vld;
    logic [NCH*DW-1:0] exp_dat;
    int                si;
    rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
    #1;
    si = int'(s);
    if (r)             exp_rdy = 1'b0;
    else if (si >= NCH) exp_rdy = 1'b1;
    else               exp_rdy = (q_m[si].size() == 0) || ordy[si];
    for (int k = 0; k < NCH; k++) begin
      exp_vld[k] = (q_m[k].size() != 0);
      exp_dat[k*DW +: DW] = exp_vld[k] ? q_m[k][0] : last_m[k];
    end
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_vld));
    check("out_data", 32'(out_data), 32'(exp_dat));
    check("drop_cnt", 32'(drop_cnt), 32'(drop_m));
    rdy_seen = in_ready;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int k = 0; k < NCH; k++)
        if (ordy[k] && q_m[k].size() != 0) void'(q_m[k].pop_front());
      if (v && exp_rdy) begin
        if (si < NCH) begin
          q_m[si].push_back(d);
          last_m[si] = d;
        end else begin
`ifdef STREAM_DEMUX_DROP_CNT_EN
          if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
`endif
        end
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic           v;
    logic [SW-1:0]  sel;
    logic [DW-1:0]  d;
    logic [NCH-1:0] ordy;
    logic           exp_rdy;
    logic [NCH-1:0] exp_vld;
    logic [31:0]    exp_dat;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic rs;
    int   cnt;
    logic [15:0] d0;

    // Routing then backpressure, starting from reset, expectations by hand.
    tbl[0] = '{1'b1, 3'd0, 8'hA0, 4'b1111, 1'b1, 4'b0001, 32'h000000A0};
    tbl[1] = '{1'b1, 3'd1, 8'hA1, 4'b1111, 1'b1, 4'b0010, 32'h0000A1A0};
    tbl[2] = '{1'b1, 3'd2, 8'hA2, 4'b1111, 1'b1, 4'b0100, 32'h00A2A1A0};
    tbl[3] = '{1'b1, 3'd3, 8'hA3, 4'b1111, 1'b1, 4'b1000, 32'hA3A2A1A0};
    tbl[4] = '{1'b1, 3'd5, 8'h55, 4'b1111, 1'b1, 4'b0000, 32'hA3A2A1A0};
    tbl[5] = '{1'b0, 3'd0, 8'h00, 4'b0000, 1'b1, 4'b0000, 32'hA3A2A1A0};
    tbl[6] = '{1'b1, 3'd2, 8'h11, 4'b1011, 1'b1, 4'b0100, 32'hA311A1A0};
    tbl[7] = '{1'b1, 3'd2, 8'h22, 4'b1011, 1'b0, 4'b0100, 32'hA311A1A0};
    tbl[8] = '{1'b1, 3'd2, 8'h22, 4'b1111, 1'b1, 4'b0100, 32'hA322A1A0};
    tbl[9] = '{1'b0, 3'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'hA322A1A0};

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with a valid word offered: in_ready must stay low.
    step(1'b1, 1'b1, 3'd0, 8'hEE, 4'b0000, rs);
    check("rst_in_ready", 32'(rs), 32'd0);

    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ordy, rs);
      check($sformatf("tbl%0d_rdy", i), 32'(rs), 32'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d_vld", i), 32'(out_valid), 32'(tbl[i].exp_vld));
      check($sformatf("tbl%0d_dat", i), out_data, tbl[i].exp_dat);
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    check("tbl_drop", 32'(drop_cnt), 32'd1);
`else
    check("tbl_drop", 32'(drop_cnt), 32'd0);
`endif

    // Independence: ch1 stalled full, 8 words alternate ch0/ch3.
    step(1'b0, 1'b1, 3'd1, 8'h77, 4'b1101, rs);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0) ? 3'd0 : 3'd3, 8'(8'h30 + i), 4'b1101, rs);
      if (rs) cnt++;
    end
    check("indep_accepts", 32'(cnt), 32'd8);
    check("indep_ch1_vld", 32'(out_valid[1]), 32'd1);
    check("indep_ch1_dat", 32'(out_data[DW +: DW]), 32'h77);

    // Out-of-range words: accepted, no valid change, counted if enabled.
    step(1'b0, 1'b0, 3'd0, 8'h00, 4'b1111, rs);
    d0 = drop_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 3'(4 + i), 8'hC0, 4'b1111, rs);
      check("oor_ready", 32'(rs), 32'd1);
      check("oor_vld", 32'(out_valid), 32'd0);
    end
`ifdef STREAM_DEMUX_DROP_CNT_EN
    check("oor_drop", 32'(drop_cnt - d0), 32'd3);
`else
    check("oor_drop", 32'(drop_cnt), 32'd0);
`endif

    // Reset mid-stream with all four channels full and stalled.
    for (int k = 0; k < NCH; k++) step(1'b0, 1'b1, 3'(k), 8'(8'h90 + k), 4'b0000, rs);
    check("fill_vld", 32'(out_valid), 32'hF);
    step(1'b1, 1'b0, 3'd0, 8'h00, 4'b0000, rs);
    check("mrst_vld", 32'(out_valid), 32'd0);
    check("mrst_dat", out_data, 32'd0);
    check("mrst_drop", 32'(drop_cnt), 32'd0);

    // Every select value against every ready pattern.
    for (int s = 0; s < 8; s++)
      for (int o = 0; o < 16; o++)
        step(1'b0, 1'b1, 3'(s), 8'($urandom), 4'(o), rs);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'b0, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           8'($urandom), 4'($urandom), rs);

    // Drain and make sure nothing was lost.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 8'h00, 4'b1111, rs);
    check("drained", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
